// File: rtl/ps2_keyboard_sequencer_pkg.sv
// PS/2 keyboard sequencer shared definitions: protocol byte constants,
// decoder/command state enums and the non-scan-byte predicate.
package ps2_seq_pkg;

    localparam logic [7:0] BYTE_E0 = 8'hE0;
    localparam logic [7:0] BYTE_F0 = 8'hF0;
    localparam logic [7:0] BYTE_FA = 8'hFA;
    localparam logic [7:0] BYTE_FE = 8'hFE;
    localparam logic [7:0] BYTE_EE = 8'hEE;
    localparam logic [7:0] BYTE_AA = 8'hAA;
    localparam logic [7:0] BYTE_ED = 8'hED;
    localparam logic [7:0] BYTE_E1 = 8'hE1;

    typedef enum logic [1:0] {
        D_IDLE,
        D_EXT,
        D_BRK,
        D_EXT_BRK
    } dec_state_e;

    typedef enum logic [2:0] {
        C_IDLE,
        C_SEND_ED,
        C_WAIT_ED,
        C_SEND_ARG,
        C_WAIT_ARG
    } cmd_state_e;

    // Bytes that are replies/status from the keyboard, never key codes.
    function automatic logic is_non_scan(input logic [7:0] b);
        return (b == BYTE_FA) || (b == BYTE_FE) ||
               (b == BYTE_EE) || (b == BYTE_AA) ||
               (b == 8'h00)   || (b == 8'hFF)   ||
               (b == BYTE_E1);
    endfunction

endpackage

// File: rtl/ps2_keyboard_sequencer_if.sv
// Transceiver-side bus: received byte strobe plus command port.
// master = sequencer (drives cmd_*), slave = transceiver.
interface ps2_keyboard_sequencer_if;

    logic [7:0] rx_data;
    logic       rx_data_en;
    logic       cmd_sent;
    logic       cmd_timeout;
    logic [7:0] cmd_data;
    logic       cmd_send;

    modport master (
        input  rx_data,
        input  rx_data_en,
        input  cmd_sent,
        input  cmd_timeout,
        output cmd_data,
        output cmd_send
    );

    modport slave (
        output rx_data,
        output rx_data_en,
        output cmd_sent,
        output cmd_timeout,
        input  cmd_data,
        input  cmd_send
    );

endinterface

// File: rtl/ps2_keyboard_sequencer_decoder.sv
// Scan-code decoder (E0/F0 prefixes) with a one-entry event buffer.
// Ports: byte_i/byte_en_i in, key_* event out, key_ack_i handshake.
module ps2_scan_decoder
    import ps2_seq_pkg::*;
(
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] byte_i,
    input  logic       byte_en_i,
    input  logic       key_ack_i,
    output logic [7:0] key_code_o,
    output logic       key_ext_o,
    output logic       key_release_o,
    output logic       key_valid_o,
    output logic       key_overrun_o
);

    dec_state_e state_q, state_d;
    logic [7:0] code_q, code_d;
    logic       ext_q, ext_d;
    logic       rel_q, rel_d;
    logic       valid_q, valid_d;
    logic       ovr_q, ovr_d;
    logic       done;
    logic       cur_ext;
    logic       cur_rel;

    assign cur_ext = (state_q == D_EXT) || (state_q == D_EXT_BRK);
    assign cur_rel = (state_q == D_BRK) || (state_q == D_EXT_BRK);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= D_IDLE;
            code_q  <= 8'h00;
            ext_q   <= 1'b0;
            rel_q   <= 1'b0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            ext_q   <= ext_d;
            rel_q   <= rel_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    // Prefix tracking; non-scan bytes leave the prefix state untouched.
    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        if (byte_en_i) begin
            unique case (1'b1)
                is_non_scan(byte_i): begin
                end
                (byte_i == BYTE_E0):
                    state_d = cur_rel ? D_EXT_BRK : D_EXT;
                (byte_i == BYTE_F0):
                    state_d = cur_ext ? D_EXT_BRK : D_BRK;
                default: begin
                    done    = 1'b1;
                    state_d = D_IDLE;
                end
            endcase
        end
    end

    // An ack in the same cycle frees the slot for the new event.
    always_comb begin
        code_d  = code_q;
        ext_d   = ext_q;
        rel_d   = rel_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (valid_q && key_ack_i) begin
            valid_d = 1'b0;
        end
        if (done) begin
            if (!valid_q || key_ack_i) begin
                code_d  = byte_i;
                ext_d   = cur_ext;
                rel_d   = cur_rel;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    assign key_code_o    = code_q;
    assign key_ext_o     = ext_q;
    assign key_release_o = rel_q;
    assign key_valid_o   = valid_q;
    assign key_overrun_o = ovr_q;

endmodule

// File: rtl/ps2_keyboard_sequencer.sv
// PS/2 sequencer: key event decode plus LED command FSM (ED+arg,
// FA/FE handling, ack timeout). xcvr: transceiver bus; led_*, key_*.
module ps2_keyboard_sequencer
    import ps2_seq_pkg::*;
#(
    parameter int ACK_TIMEOUT = 1_000_000,
    parameter int MAX_RETRIES = 2
) (
    input  logic                      CLOCK_50,
    input  logic                      reset,
    ps2_keyboard_sequencer_if.master  xcvr,
    input  logic                      led_req,
    input  logic [2:0]                led_value,
    output logic                      led_busy,
    output logic                      cfg_error,
    output logic [7:0]                key_code,
    output logic                      key_ext,
    output logic                      key_release,
    output logic                      key_valid,
    input  logic                      key_ack,
    output logic                      key_overrun
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRIES + 2);

    cmd_state_e      state_q, state_d;
    logic [7:0]      arg_q, arg_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic            err_q, err_d;
    logic            waiting;
    logic            rx_fa;
    logic            rx_fe;
    logic            dec_en;

    assign waiting = (state_q == C_WAIT_ED) ||
                     (state_q == C_WAIT_ARG);
    assign rx_fa = xcvr.rx_data_en && (xcvr.rx_data == BYTE_FA);
    assign rx_fe = xcvr.rx_data_en && (xcvr.rx_data == BYTE_FE);

    // Replies are swallowed only while a reply is expected.
    assign dec_en = xcvr.rx_data_en && !(waiting && (rx_fa || rx_fe));

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= C_IDLE;
            arg_q   <= 8'h00;
            timer_q <= '0;
            retry_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            arg_q   <= arg_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
            err_q   <= err_d;
        end
    end

    // Timer is zero in every non-wait state, so it starts at 0
    // on the first wait cycle; timeout decision on cycle ACK_TIMEOUT.
    always_comb begin
        state_d = state_q;
        arg_d   = arg_q;
        timer_d = '0;
        retry_d = retry_q;
        err_d   = err_q;
        unique case (state_q)
            C_IDLE: begin
                if (led_req) begin
                    arg_d   = {5'b0, led_value};
                    retry_d = '0;
                    state_d = C_SEND_ED;
                end
            end
            C_SEND_ED, C_SEND_ARG: begin
                if (xcvr.cmd_sent) begin
                    state_d = (state_q == C_SEND_ED) ?
                              C_WAIT_ED : C_WAIT_ARG;
                end else if (xcvr.cmd_timeout) begin
                    err_d   = 1'b1;
                    state_d = C_IDLE;
                end
            end
            C_WAIT_ED, C_WAIT_ARG: begin
                timer_d = timer_q + 1'b1;
                if (rx_fa) begin
                    retry_d = '0;
                    state_d = (state_q == C_WAIT_ED) ?
                              C_SEND_ARG : C_IDLE;
                end else if (rx_fe) begin
                    if (retry_q < RW'(MAX_RETRIES)) begin
                        retry_d = retry_q + 1'b1;
                        state_d = (state_q == C_WAIT_ED) ?
                                  C_SEND_ED : C_SEND_ARG;
                    end else begin
                        err_d   = 1'b1;
                        state_d = C_IDLE;
                    end
                end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = C_IDLE;
                end
            end
            default: state_d = C_IDLE;
        endcase
    end

    always_comb begin
        xcvr.cmd_send = 1'b0;
        xcvr.cmd_data = 8'h00;
        if (state_q == C_SEND_ED) begin
            xcvr.cmd_send = 1'b1;
            xcvr.cmd_data = BYTE_ED;
        end else if (state_q == C_SEND_ARG) begin
            xcvr.cmd_send = 1'b1;
            xcvr.cmd_data = arg_q;
        end
    end

    assign led_busy  = (state_q != C_IDLE);
    assign cfg_error = err_q;

    ps2_scan_decoder u_dec (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .byte_i        (xcvr.rx_data),
        .byte_en_i     (dec_en),
        .key_ack_i     (key_ack),
        .key_code_o    (key_code),
        .key_ext_o     (key_ext),
        .key_release_o (key_release),
        .key_valid_o   (key_valid),
        .key_overrun_o (key_overrun)
    );

endmodule

// File: tb/tb_ps2_keyboard_sequencer.sv
// Self-checking bench for ps2_keyboard_sequencer.
// Table of byte vectors plus hand-written command sequences.
module tb_ps2_keyboard_sequencer;
    import ps2_seq_pkg::*;

    localparam int ACK_TO = 100;
    localparam int MAXR   = 2;

    typedef struct {
        logic [7:0] b;
        logic       v;
        logic [9:0] ev;
    } vec_t;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic       led_req  = 1'b0;
    logic [2:0] led_value = 3'b000;
    logic       led_busy;
    logic       cfg_error;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_release;
    logic       key_valid;
    logic       key_ack  = 1'b0;
    logic       key_overrun;

    int total = 0;
    int bad   = 0;
    int ed_sends = 0;

    logic [9:0] ev_q[$];
    logic [7:0] cmd_q[$];
    vec_t       vecs[18];

    ps2_keyboard_sequencer_if x();

    ps2_keyboard_sequencer #(
        .ACK_TIMEOUT (ACK_TO),
        .MAX_RETRIES (MAXR)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .xcvr        (x),
        .led_req     (led_req),
        .led_value   (led_value),
        .led_busy    (led_busy),
        .cfg_error   (cfg_error),
        .key_code    (key_code),
        .key_ext     (key_ext),
        .key_release (key_release),
        .key_valid   (key_valid),
        .key_ack     (key_ack),
        .key_overrun (key_overrun)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    initial begin
        #2000000;
        $display("FAIL watchdog act=running req=finished");
        $fatal(1);
    end

    function automatic vec_t mk(input logic [7:0] b, input logic v,
                                input logic [7:0] c, input logic e,
                                input logic r);
        vec_t t;
        t.b  = b;
        t.v  = v;
        t.ev = {c, e, r};
        return t;
    endfunction

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s act=%0h req=%0h", n, a, e);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        x.rx_data    = b;
        x.rx_data_en = 1'b1;
        tick();
        x.rx_data_en = 1'b0;
    endtask

    task automatic take_event();
        logic [9:0] e;
        chk("key_valid", 32'(key_valid), 1);
        if (ev_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL ev_q act=empty req=entry");
        end else begin
            e = ev_q.pop_front();
            chk("event", 32'({key_code, key_ext, key_release}),
                32'(e));
        end
        key_ack = 1'b1;
        tick();
        key_ack = 1'b0;
        chk("key_valid_clr", 32'(key_valid), 0);
    endtask

    task automatic serve_cmd(input int hold);
        int n;
        logic [7:0] e;
        n = 0;
        while (!x.cmd_send && n < 20) begin
            tick();
            n++;
        end
        chk("cmd_send_up", 32'(x.cmd_send), 1);
        e = 8'hxx;
        if (cmd_q.size() != 0) e = cmd_q.pop_front();
        chk("cmd_data", 32'(x.cmd_data), 32'(e));
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("cmd_hold", 32'({x.cmd_send, x.cmd_data}),
                32'({1'b1, e}));
        end
        if (x.cmd_data == BYTE_ED) ed_sends++;
        x.cmd_sent = 1'b1;
        tick();
        x.cmd_sent = 1'b0;
        chk("cmd_send_drop", 32'(x.cmd_send), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("reset_outs",
            32'({x.cmd_send, x.cmd_data, led_busy, cfg_error,
                 key_code, key_ext, key_release, key_valid,
                 key_overrun}), 0);
    endtask

    task automatic req_led(input logic [2:0] v);
        led_req   = 1'b1;
        led_value = v;
        tick();
        led_req   = 1'b0;
        chk("req_send", 32'({x.cmd_send, led_busy}), 32'h3);
    endtask

    initial begin
        x.rx_data     = 8'h00;
        x.rx_data_en  = 1'b0;
        x.cmd_sent    = 1'b0;
        x.cmd_timeout = 1'b0;

        vecs[0]  = mk(8'h1C, 1, 8'h1C, 0, 0);
        vecs[1]  = mk(8'hE0, 0, 8'h00, 0, 0);
        vecs[2]  = mk(8'hF0, 0, 8'h00, 0, 0);
        vecs[3]  = mk(8'h75, 1, 8'h75, 1, 1);
        vecs[4]  = mk(8'hF0, 0, 8'h00, 0, 0);
        vecs[5]  = mk(8'h1C, 1, 8'h1C, 0, 1);
        vecs[6]  = mk(8'hE0, 0, 8'h00, 0, 0);
        vecs[7]  = mk(8'hFA, 0, 8'h00, 0, 0);
        vecs[8]  = mk(8'h6B, 1, 8'h6B, 1, 0);
        vecs[9]  = mk(8'hAA, 0, 8'h00, 0, 0);
        vecs[10] = mk(8'hE0, 0, 8'h00, 0, 0);
        vecs[11] = mk(8'hEE, 0, 8'h00, 0, 0);
        vecs[12] = mk(8'hF0, 0, 8'h00, 0, 0);
        vecs[13] = mk(8'h74, 1, 8'h74, 1, 1);
        vecs[14] = mk(8'h00, 0, 8'h00, 0, 0);
        vecs[15] = mk(8'hFF, 0, 8'h00, 0, 0);
        vecs[16] = mk(8'hE1, 0, 8'h00, 0, 0);
        vecs[17] = mk(8'h29, 1, 8'h29, 0, 0);

        repeat (3) tick();
        reset = 1'b0;
        chk("reset_outs",
            32'({x.cmd_send, x.cmd_data, led_busy, cfg_error,
                 key_code, key_ext, key_release, key_valid,
                 key_overrun}), 0);

        // decoder vectors
        for (int i = 0; i < 18; i++) begin
            if (vecs[i].v) ev_q.push_back(vecs[i].ev);
            send_byte(vecs[i].b);
            chk("vec_valid", 32'(key_valid), 32'(vecs[i].v));
            if (vecs[i].v) take_event();
        end

        // overrun: second event dropped, first retained
        send_byte(8'h1C);
        send_byte(8'h32);
        chk("ovr_flag", 32'(key_overrun), 1);
        chk("ovr_keep", 32'({key_valid, key_code}), 32'h11C);
        // ack coinciding with a completion loads the new event
        key_ack      = 1'b1;
        x.rx_data    = 8'h21;
        x.rx_data_en = 1'b1;
        tick();
        key_ack      = 1'b0;
        x.rx_data_en = 1'b0;
        ev_q.push_back({8'h21, 1'b0, 1'b0});
        take_event();
        chk("ovr_sticky", 32'(key_overrun), 1);
        do_reset();

        // LED update success, with a scan byte during the wait
        req_led(3'b101);
        cmd_q.push_back(BYTE_ED);
        cmd_q.push_back(8'h05);
        serve_cmd(2);
        led_req   = 1'b1;
        led_value = 3'b111;
        tick();
        led_req   = 1'b0;
        ev_q.push_back({8'h1C, 1'b0, 1'b0});
        send_byte(8'h1C);
        take_event();
        send_byte(BYTE_FA);
        chk("fa_no_event", 32'(key_valid), 0);
        serve_cmd(1);
        send_byte(BYTE_FA);
        chk("led_done", 32'({led_busy, cfg_error}), 0);

        // FE resends then give up
        ed_sends = 0;
        req_led(3'b010);
        for (int i = 0; i < 3; i++) begin
            cmd_q.push_back(BYTE_ED);
            serve_cmd(0);
            send_byte(BYTE_FE);
        end
        chk("ed_sends", 32'(ed_sends), 3);
        chk("fe_fail", 32'({cfg_error, led_busy, x.cmd_send}),
            32'h4);
        do_reset();

        // transceiver timeout while sending
        req_led(3'b001);
        x.cmd_timeout = 1'b1;
        tick();
        x.cmd_timeout = 1'b0;
        chk("send_to", 32'({cfg_error, led_busy}), 32'h2);
        do_reset();

        // ack timeout: decision on wait cycle ACK_TO
        req_led(3'b001);
        cmd_q.push_back(BYTE_ED);
        serve_cmd(0);
        repeat (ACK_TO - 2) tick();
        chk("to_c99", 32'({cfg_error, led_busy}), 32'h1);
        tick();
        chk("to_c100", 32'({cfg_error, led_busy}), 32'h1);
        tick();
        chk("to_fire", 32'({cfg_error, led_busy}), 32'h2);
        do_reset();

        // FA on the timeout cycle wins
        req_led(3'b110);
        cmd_q.push_back(BYTE_ED);
        cmd_q.push_back(8'h06);
        serve_cmd(0);
        repeat (ACK_TO - 1) tick();
        send_byte(BYTE_FA);
        chk("fa_wins", 32'({cfg_error, x.cmd_send, x.cmd_data}),
            32'h106);
        serve_cmd(0);

        // reset in C_WAIT_ARG with a pending E0 prefix
        send_byte(BYTE_E0);
        reset = 1'b1;
        tick();
        chk("mid_reset",
            32'({x.cmd_send, x.cmd_data, led_busy, cfg_error,
                 key_code, key_ext, key_release, key_valid,
                 key_overrun}), 0);
        reset = 1'b0;
        ev_q.push_back({8'h1C, 1'b0, 1'b0});
        send_byte(8'h1C);
        take_event();
        chk("idle_after", 32'(led_busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
